// File: rtl/ppu_bg_fifo.sv
// rtl/ppu_bg_fifo.sv - background pixel FIFO/shifter between tile fetcher and LCD path.
// Optional BGP palette mapping when PPU_BG_PALETTE_EN is defined.
module ppu_bg_fifo #(
   parameter int SCREEN_W = 160,
   parameter int DEPTH    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_start,
   input  logic [2:0] fine_x,
   input  logic       bg_ena,
   input  logic [7:0] bgp,
   input  logic       push,
   input  logic [7:0] data_low,
   input  logic [7:0] data_high,
   output logic       push_ready,
   output logic       px_valid,
   output logic [1:0] px_color,
   output logic [7:0] px_x,
   output logic       line_done
);

   localparam logic [7:0] X_LAST   = 8'(SCREEN_W - 1);
   localparam logic [4:0] READY_LIM = 5'(DEPTH - 8);

   logic [1:0] fifo_q [DEPTH];
   logic [1:0] fifo_d [DEPTH];
   logic [4:0] count_q, count_d;
   logic       active_q, active_d;
   logic [2:0] discard_q, discard_d;
   logic [7:0] x_q, x_d;
   logic       px_valid_q, px_valid_d;
   logic [1:0] px_color_q, px_color_d;
   logic [7:0] px_x_q, px_x_d;
   logic       line_done_q, line_done_d;

   logic       push_acc;
   logic       pop;
   logic [4:0] base;
   logic [4:0] wr;
   logic [1:0] head_idx;
   logic [1:0] head_color;

   assign push_ready = (count_q <= READY_LIM);
   assign push_acc   = push && push_ready && !line_start;
   assign pop        = active_q && (count_q != 5'd0) && !line_start;
   assign head_idx   = bg_ena ? fifo_q[0] : 2'd0;

`ifdef PPU_BG_PALETTE_EN
   assign head_color = bgp[{head_idx, 1'b0} +: 2];
`else
   logic [7:0] unused_bgp;
   assign unused_bgp = bgp;
   assign head_color = head_idx;
`endif

   always_comb begin
      fifo_d      = fifo_q;
      count_d     = count_q;
      active_d    = active_q;
      discard_d   = discard_q;
      x_d         = x_q;
      px_valid_d  = 1'b0;
      px_color_d  = px_color_q;
      px_x_d      = px_x_q;
      line_done_d = 1'b0;
      base        = count_q - {4'd0, pop};
      wr          = 5'd0;

      if (line_start) begin
         count_d   = 5'd0;
         active_d  = 1'b1;
         discard_d = fine_x;
         x_d       = 8'd0;
      end else begin
         if (pop) begin
            // Head is entry 0; shift everything one slot toward it.
            for (int i = 0; i < DEPTH - 1; i++) begin
               fifo_d[i] = fifo_q[i + 1];
            end
            if (discard_q != 3'd0) begin
               discard_d = discard_q - 3'd1;
            end else begin
               px_valid_d = 1'b1;
               px_color_d = head_color;
               px_x_d     = x_q;
               if (x_q == X_LAST) begin
                  active_d    = 1'b0;
                  line_done_d = 1'b1;
               end else begin
                  x_d = x_q + 8'd1;
               end
            end
         end
         if (push_acc) begin
            // Appended behind whatever survives this cycle's pop.
            for (int i = 0; i < 8; i++) begin
               wr = base + 5'(i);
               fifo_d[wr[3:0]] = {data_high[7 - i], data_low[7 - i]};
            end
         end
         count_d = count_q + (push_acc ? 5'd8 : 5'd0) - {4'd0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= 2'd0;
         end
         count_q     <= 5'd0;
         active_q    <= 1'b0;
         discard_q   <= 3'd0;
         x_q         <= 8'd0;
         px_valid_q  <= 1'b0;
         px_color_q  <= 2'd0;
         px_x_q      <= 8'd0;
         line_done_q <= 1'b0;
      end else begin
         fifo_q      <= fifo_d;
         count_q     <= count_d;
         active_q    <= active_d;
         discard_q   <= discard_d;
         x_q         <= x_d;
         px_valid_q  <= px_valid_d;
         px_color_q  <= px_color_d;
         px_x_q      <= px_x_d;
         line_done_q <= line_done_d;
      end
   end

   assign px_valid  = px_valid_q;
   assign px_color  = px_color_q;
   assign px_x      = px_x_q;
   assign line_done = line_done_q;

endmodule

// File: tb/tb_ppu_bg_fifo.sv
// tb/tb_ppu_bg_fifo.sv - self-checking bench for ppu_bg_fifo with a queue-based pixel model.
module tb_ppu_bg_fifo;

   logic       clk = 1'b0;
   logic       rst, line_start, bg_ena, push;
   logic [2:0] fine_x;
   logic [7:0] bgp, data_low, data_high;
   logic       push_ready, px_valid, line_done;
   logic [1:0] px_color;
   logic [7:0] px_x;

`ifdef PPU_BG_PALETTE_EN
   localparam bit USE_PAL = 1'b1;
`else
   localparam bit USE_PAL = 1'b0;
`endif

   ppu_bg_fifo dut (
      .clk(clk), .rst(rst), .line_start(line_start), .fine_x(fine_x),
      .bg_ena(bg_ena), .bgp(bgp), .push(push), .data_low(data_low),
      .data_high(data_high), .push_ready(push_ready), .px_valid(px_valid),
      .px_color(px_color), .px_x(px_x), .line_done(line_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: pixel queue plus line bookkeeping
   int mq[$];
   bit m_active;
   int m_disc;
   int m_x;
   bit e_valid, e_done;
   int e_color, e_x;

   function automatic int pal(int p, bit ena, logic [7:0] pb);
      int idx = ena ? p : 0;
      int pv  = (int'(pb) >> (2 * idx)) & 3;
      return USE_PAL ? pv : idx;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_active = 0; m_disc = 0; m_x = 0;
      e_valid = 0; e_done = 0; e_color = 0; e_x = 0;
   endtask

   task automatic model_step();
      bit ready = (mq.size() <= 8);
      int p;
      if (rst) begin
         model_reset();
         return;
      end
      e_valid = 0;
      e_done  = 0;
      if (line_start) begin
         mq.delete();
         m_active = 1; m_disc = int'(fine_x); m_x = 0;
         return;
      end
      if (m_active && mq.size() > 0) begin
         p = mq.pop_front();
         if (m_disc > 0) m_disc--;
         else begin
            e_valid = 1; e_x = m_x; e_color = pal(p, bg_ena, bgp);
            if (m_x == 159) begin e_done = 1; m_active = 0; end
            else m_x++;
         end
      end
      if (push && ready)
         for (int i = 7; i >= 0; i--) mq.push_back({int'(data_high[i]) * 2 + int'(data_low[i])});
   endtask

   task automatic tick_model();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ls(input logic [2:0] fx);
      line_start = 1; fine_x = fx;
      tick_model();
      line_start = 0;
   endtask

   task automatic do_push(input logic [7:0] lo, input logic [7:0] hi);
      push = 1; data_low = lo; data_high = hi;
      tick_model();
      push = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      tick_model();
      tick_model();
      rst = 0;
      checks++; if (push_ready !== 1'b1) begin failures++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
      checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL reset_px_valid got=%b exp=0", px_valid); end
      checks++; if (line_done !== 1'b0) begin failures++; $display("FAIL reset_line_done got=%b exp=0", line_done); end
      checks++; if (px_color !== 2'd0) begin failures++; $display("FAIL reset_px_color got=%0d exp=0", px_color); end
      checks++; if (px_x !== 8'd0) begin failures++; $display("FAIL reset_px_x got=%0d exp=0", px_x); end
   endtask

   task automatic test_basic_row();
      bg_ena = 1;
      do_ls(3'd0);
      do_push(8'hFF, 8'h00);
      checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL basic_latency got=%b exp=0", px_valid); end
      for (int i = 0; i < 8; i++) begin
         tick_model();
         checks++;
         if (px_valid !== 1'b1 || px_x !== 8'(i) || px_color !== 2'd1 || line_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_row[%0d] got v=%b x=%0d c=%0d d=%b exp v=1 x=%0d c=1 d=0", i, px_valid, px_x, px_color, line_done, i);
         end
      end
      tick_model();
      checks++; if (px_valid !== 1'b0) begin failures++; $display("FAIL basic_underflow got=%b exp=0", px_valid); end
   endtask

   task automatic test_bit_order();
      int exp_c[8] = '{1, 0, 0, 0, 0, 0, 0, 2};
      do_push(8'h80, 8'h01);
      for (int i = 0; i < 8; i++) begin
         tick_model();
         checks++;
         if (px_valid !== 1'b1 || px_x !== 8'(8 + i) || px_color !== 2'(exp_c[i])) begin
            failures++;
            $display("FAIL bit_order[%0d] got v=%b x=%0d c=%0d exp v=1 x=%0d c=%0d", i, px_valid, px_x, px_color, 8 + i, exp_c[i]);
         end
      end
   endtask

   task automatic test_fine_scroll();
      int got_c[$];
      int got_x[$];
      int exp_c[13] = '{0, 1, 1, 1, 1, 3, 3, 3, 3, 3, 3, 3, 3};
      do_ls(3'd3);
      do_push(8'h0F, 8'h00);
      do_push(8'hFF, 8'hFF);
      for (int i = 0; i < 24; i++) begin
         tick_model();
         if (px_valid === 1'b1) begin got_c.push_back(int'(px_color)); got_x.push_back(int'(px_x)); end
      end
      checks++;
      if (got_c.size() != 13) begin
         failures++; $display("FAIL fine_scroll_count got=%0d exp=13", got_c.size());
      end else begin
         for (int k = 0; k < 13; k++) begin
            checks++;
            if (got_c[k] != exp_c[k] || got_x[k] != k) begin
               failures++;
               $display("FAIL fine_scroll[%0d] got c=%0d x=%0d exp c=%0d x=%0d", k, got_c[k], got_x[k], exp_c[k], k);
            end
         end
      end
   endtask

   task automatic test_full_line();
      int rows = 0, nvalid = 0, after_done = 0, bad = 0, idle = 0;
      bit seen_done = 0;
      do_ls(3'd0);
      for (int cyc = 0; cyc < 600 && idle < 20; cyc++) begin
         push = push_ready && (rows < 21);
         if (push) begin data_low = 8'($urandom); data_high = 8'($urandom); rows++; end
         bgp = 8'($urandom);
         tick_model();
         push = 0;
         if (px_valid !== e_valid || line_done !== e_done || push_ready !== (mq.size() <= 8) ||
             (e_valid && (px_x !== 8'(e_x) || px_color !== 2'(e_color)))) bad++;
         if (px_valid === 1'b1) begin
            if (seen_done) after_done++;
            else begin
               if (px_x !== 8'(nvalid)) bad++;
               nvalid++;
            end
         end
         if (line_done === 1'b1) begin
            if (px_valid !== 1'b1 || px_x !== 8'd159) bad++;
            seen_done = 1;
         end
         if (seen_done) idle++;
      end
      checks++; if (!seen_done) begin failures++; $display("FAIL full_line_timeout got done=0 exp done=1"); end
      checks++; if (nvalid != 160) begin failures++; $display("FAIL full_line_count got=%0d exp=160", nvalid); end
      checks++; if (after_done != 0) begin failures++; $display("FAIL full_line_after_done got=%0d exp=0", after_done); end
      checks++; if (bad != 0) begin failures++; $display("FAIL full_line_cycles got bad=%0d exp=0", bad); end
   endtask

   task automatic test_restart();
      bit found = 0;
      bit first_seen = 0;
      int first_x = -1, dones = 0;
      do_ls(3'd0);
      for (int cyc = 0; cyc < 300 && !found; cyc++) begin
         push = push_ready;
         data_low = 8'($urandom); data_high = 8'($urandom);
         tick_model();
         push = 0;
         if (px_valid === 1'b1 && px_x === 8'd50) found = 1;
      end
      checks++; if (!found) begin failures++; $display("FAIL restart_reach50 got=0 exp=1"); end
      do_ls(3'd0);
      for (int cyc = 0; cyc < 40; cyc++) begin
         push = push_ready;
         tick_model();
         push = 0;
         if (line_done === 1'b1) dones++;
         if (px_valid === 1'b1 && !first_seen) begin first_seen = 1; first_x = int'(px_x); end
      end
      checks++; if (first_x != 0) begin failures++; $display("FAIL restart_first_x got=%0d exp=0", first_x); end
      checks++; if (dones != 0) begin failures++; $display("FAIL restart_line_done got=%0d exp=0", dones); end
   endtask

   task automatic test_palette();
      int exp1 = 0;
      int exp2 = USE_PAL ? 3 : 0;
      int exp3 = USE_PAL ? 3 : 0;
      bg_ena = 1; bgp = 8'hE4;
      do_ls(3'd0); do_push(8'h00, 8'h00); tick_model();
      checks++; if (px_valid !== 1'b1 || px_color !== 2'(exp1)) begin failures++; $display("FAIL pal_e4 got v=%b c=%0d exp v=1 c=%0d", px_valid, px_color, exp1); end
      bgp = 8'h1B;
      do_ls(3'd0); do_push(8'h00, 8'h00); tick_model();
      checks++; if (px_valid !== 1'b1 || px_color !== 2'(exp2)) begin failures++; $display("FAIL pal_1b got v=%b c=%0d exp v=1 c=%0d", px_valid, px_color, exp2); end
      bg_ena = 0;
      do_ls(3'd0); do_push(8'hFF, 8'hFF); tick_model();
      checks++; if (px_valid !== 1'b1 || px_color !== 2'(exp3)) begin failures++; $display("FAIL pal_bg_off got v=%b c=%0d exp v=1 c=%0d", px_valid, px_color, exp3); end
      bg_ena = 1;
   endtask

   task automatic test_random();
      int bad = 0, emitted = 0;
      do_ls(3'($urandom));
      for (int cyc = 0; cyc < 4000; cyc++) begin
         line_start = ($urandom_range(0, 299) == 0);
         fine_x    = 3'($urandom);
         push      = ($urandom_range(0, 2) != 0);
         data_low  = 8'($urandom);
         data_high = 8'($urandom);
         bg_ena    = ($urandom_range(0, 7) != 0);
         bgp       = 8'($urandom);
         tick_model();
         if (px_valid === 1'b1) emitted++;
         if (px_valid !== e_valid || line_done !== e_done || push_ready !== (mq.size() <= 8) ||
             (e_valid && (px_x !== 8'(e_x) || px_color !== 2'(e_color)))) begin
            bad++;
            if (bad <= 5) $display("FAIL random_cycle%0d got v=%b d=%b r=%b x=%0d c=%0d exp v=%b d=%b r=%b x=%0d c=%0d",
               cyc, px_valid, line_done, push_ready, px_x, px_color, e_valid, e_done, (mq.size() <= 8), e_x, e_color);
         end
      end
      line_start = 0; push = 0; bg_ena = 1;
      checks++; if (bad != 0) begin failures++; $display("FAIL random_total got bad=%0d exp=0", bad); end
      checks++; if (emitted == 0) begin failures++; $display("FAIL random_activity got=0 exp>0"); end
   endtask

   initial begin
      rst = 1; line_start = 0; fine_x = 0; bg_ena = 1; bgp = 8'hE4;
      push = 0; data_low = 0; data_high = 0;
      model_reset();
      #1;
      test_reset();
      test_basic_row();
      test_bit_order();
      test_fine_scroll();
      test_full_line();
      test_restart();
      test_palette();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
